dma_burst_controller: RTL and testbench
=======================================

# dma_burst_controller

Sequencing engine for port B of the 512×32 custom-instruction scratchpad SSRAM. It moves blocks of words between that memory and the system bus as a bus master, and splits each block into bursts. The CPU configures and starts it through custom-instruction writes and polls its status through custom-instruction reads. It sits beside the scratchpad and drives port B exclusively.

## Interface
- `customId`, default `8'h00`: custom-instruction number this block answers to.
- `clock` input 1: single system clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: CI strobe. Also `valueA` input 32, `valueB` input 32, `ciN` input 8.
- `done` output 1 and `result` output 32: CI completion and read data.
- `ramAddressB` output 9, `ramWriteEnableB` output 1, `ramDataOutB` output 32: port B address, write enable and write data.
- `ramDataInB` input 32: port B read data. Read latency is one cycle.
- `busRequest` output 1, `busGrant` input 1: bus arbitration.
- `busBeginTransaction` output 1, `busAddress` output 32, `busBurstSize` output 8 (beats − 1), `busReadNotWrite` output 1: transaction header.
- `busDataIn` input 32, `busDataValid` input 1: read beats.
- `busDataOut` output 32, `busDataValidOut` output 1, `busBusy` input 1: write beats.
- `busEndTransaction` output 1, `busEndIn` input 1, `busError` input 1: transaction termination.

## Operation
- **CI decode.** A CI is accepted when `start` is high and `ciN == customId`.
  - `valueA[12:10]` selects the register and `valueA[9]` set means write; `valueB` is the write data.
  - `valueA[31:13] != 0` or an unknown select gives `done` with `result = 0` and no side effect.
- **Register map.**
  - 1: bus start address, 32 bits. Bits [1:0] are forced to 0.
  - 2: memory start address, 9 bits.
  - 3: block size in words, 10 bits, range 0–512.
  - 4: burst size, 8 bits. Beats per burst = value + 1.
  - 5: control/status.
    - Write value 1 starts bus→memory; write value 2 starts memory→bus.
    - Read returns {30'b0, error, busy}.
  - A read of any register returns its current value.
- **Start rules.**
  - A start is ignored while busy or when block size is 0.
  - A start clears error, loads the working counters and sets busy.
  - Writes to registers 1–4 while busy update the shadow registers only; the running transfer is unaffected.
- **FSM states:**
  - IDLE: no transfer in progress.
  - REQ: `busRequest` high; on `busGrant` go to HDR.
  - HDR: `busBeginTransaction` high for one cycle. Header is `busAddress` = working address, `busBurstSize` = min(remaining, beats) − 1, and direction. Next state is RD, or PRE for a write.
  - RD: for each `busDataValid`, write `busDataIn` to `ramAddressB` and post-increment the address. When the beat count reaches the header length, go to NEXT.
  - PRE: issue the port B read; next state WR.
  - WR: drive `busDataOut`/`busDataValidOut`.
    - On a cycle with `busBusy` low, the beat is consumed and the next word is prefetched.
    - While `busBusy` is high, the data is held stable.
    - After the last beat, pulse `busEndTransaction` and go to NEXT.
  - NEXT: bus address += 4×beats and remaining −= beats. If remaining is 0, clear busy and go to IDLE; otherwise go to REQ.
- **Arithmetic.**
  - The memory address is 9 bits and wraps from 511 to 0.
  - The bus address wraps modulo 2^32.
- **Error handling.** `busError`, or `busEndIn` arriving before the last beat, in any of RD/WR/HDR:
  - abort to IDLE and drop `busRequest`;
  - set error and clear busy;
  - leave the remaining count frozen, readable via register 3 shadow semantics (register 3 reads the shadow).
- Port B outputs are 0 whenever the FSM is not in RD/PRE/WR.

## Timing
- A CI is answered with `done` for exactly one cycle, one cycle after `start`; `result` is valid in that same cycle and returns to 0 afterwards.
- A control write starting a transfer makes busy readable as 1 by the next CI.
- `busRequest` rises one cycle after the start CI is accepted.
- A read beat reaches RAM in the same cycle as `busDataValid`, with no buffering.
- Write path: one cycle in PRE, then one beat per cycle while `busBusy` is low.
- Reset (low) values:
  - all outputs 0, FSM in IDLE;
  - registers 0, busy 0, error 0.
- Reset mid-transfer drops `busRequest` asynchronously. No end-of-transaction is issued.

## Configuration
- Macro `DMA_BURST_EN`.
- When defined: bursts use register 4 as described above.
- When undefined: register 4 reads 0 and ignores writes, and every transaction is a single beat (`busBurstSize` = 0).

## Test plan
- Write/read back: bus start 0x4000_0000, mem start 10, block 8, burst 3 → each CI read returns the written value with a one-cycle `done`.
- Bus→memory, block 8, burst 3: two HDR cycles with addresses 0x4000_0000 and 0x4000_0010, `busBurstSize` 3 each. Data 0..7 land at memory 10..17; status reads 0 at the end.
- Memory→bus, block 5, burst 3, `busBusy` asserted on beat 2 for 3 cycles → bursts of 4 and 1 beats, the held data is unchanged during `busBusy`, and `busEndTransaction` pulses once per burst.
- Wrap: mem start 510, block 4, bus→memory → words written to 510, 511, 0, 1.
- `busError` on beat 2 → `busRequest` low the next cycle and status = 2. A new start clears error and the transfer completes.
- Start with block 0, and start while busy → both ignored, with status unchanged.

Source files
------------

// File: rtl/dma_burst_controller.sv
// DMA sequencer for scratchpad port B: CI-programmed block moves between the SSRAM and the system bus.
// Feature macro DMA_BURST_EN enables multi-beat bursts via register 4; otherwise every transaction is one beat.
module dma_burst_controller #(
    parameter logic [7:0] customId = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  ciN,
    output logic        done,
    output logic [31:0] result,
    output logic [8:0]  ramAddressB,
    output logic        ramWriteEnableB,
    output logic [31:0] ramDataOutB,
    input  logic [31:0] ramDataInB,
    output logic        busRequest,
    input  logic        busGrant,
    output logic        busBeginTransaction,
    output logic [31:0] busAddress,
    output logic [7:0]  busBurstSize,
    output logic        busReadNotWrite,
    input  logic [31:0] busDataIn,
    input  logic        busDataValid,
    output logic [31:0] busDataOut,
    output logic        busDataValidOut,
    input  logic        busBusy,
    output logic        busEndTransaction,
    input  logic        busEndIn,
    input  logic        busError
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_HDR  = 3'd2,
        S_RD   = 3'd3,
        S_PRE  = 3'd4,
        S_WR   = 3'd5,
        S_NEXT = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic        abort_s;

    logic [31:0] bus_start_r;
    logic [8:0]  mem_start_r;
    logic [9:0]  block_r;
    logic [7:0]  burst_val_s;
    logic        busy_r;
    logic        error_r;

    logic [31:0] wk_bus_r;
    logic [8:0]  wk_mem_r;
    logic [9:0]  remaining_r;
    logic [7:0]  wk_burst_r;
    logic        dir_rd_r;
    logic [8:0]  hdr_len_r;
    logic [8:0]  beat_cnt_r;
    logic        fresh_r;
    logic [31:0] hold_r;

    logic        ci_accept_s;
    logic        ci_legal_s;
    logic [2:0]  ci_sel_s;
    logic        reg_wr_s;
    logic        start_s;
    logic [31:0] rd_val_s;
    logic [8:0]  beats_s;
    logic [8:0]  hdr_len_s;
    logic [8:0]  hdr_m1_s;
    logic        last_beat_s;
    logic        unused_ok_s;

    assign ci_accept_s = start && (ciN == customId);
    assign ci_legal_s  = (valueA[31:13] == 19'd0);
    assign ci_sel_s    = valueA[12:10];
    assign reg_wr_s    = ci_accept_s && ci_legal_s && valueA[9];
    assign start_s     = reg_wr_s && (ci_sel_s == 3'd5) && !busy_r && (block_r != 10'd0)
                         && ((valueB == 32'd1) || (valueB == 32'd2));
    assign unused_ok_s = ^valueA[8:0];

    assign beats_s     = {1'b0, wk_burst_r} + 9'd1;
    assign hdr_len_s   = (remaining_r < {1'b0, beats_s}) ? remaining_r[8:0] : beats_s;
    assign hdr_m1_s    = hdr_len_s - 9'd1;
    assign last_beat_s = ((beat_cnt_r + 9'd1) == hdr_len_r);

`ifdef DMA_BURST_EN
    logic [7:0] burst_r;

    // Burst-length shadow register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            burst_r <= 8'd0;
        end else if (reg_wr_s && (ci_sel_s == 3'd4)) begin
            burst_r <= valueB[7:0];
        end
    end

    assign burst_val_s = burst_r;
`else
    assign burst_val_s = 8'd0;
`endif

    // Register read multiplexer
    always_comb begin
        rd_val_s = 32'd0;
        case (ci_sel_s)
            3'd1:    rd_val_s = bus_start_r;
            3'd2:    rd_val_s = {23'd0, mem_start_r};
            3'd3:    rd_val_s = {22'd0, block_r};
            3'd4:    rd_val_s = {24'd0, burst_val_s};
            3'd5:    rd_val_s = {30'd0, error_r, busy_r};
            default: rd_val_s = 32'd0;
        endcase
    end

    // CI response: one-cycle done with read data, zero otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done   <= 1'b0;
            result <= 32'd0;
        end else begin
            done   <= ci_accept_s;
            result <= (ci_accept_s && ci_legal_s && !valueA[9]) ? rd_val_s : 32'd0;
        end
    end

    // Configuration shadow registers; the running transfer uses working copies
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_start_r <= 32'd0;
            mem_start_r <= 9'd0;
            block_r     <= 10'd0;
        end else if (reg_wr_s) begin
            case (ci_sel_s)
                3'd1:    bus_start_r <= {valueB[31:2], 2'b00};
                3'd2:    mem_start_r <= valueB[8:0];
                3'd3:    block_r     <= valueB[9:0];
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state and abort detection
    always_comb begin
        state_nx_s = state_r;
        abort_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_nx_s = S_REQ;
                else         state_nx_s = S_IDLE;
            end
            S_REQ: begin
                if (busGrant) state_nx_s = S_HDR;
                else          state_nx_s = S_REQ;
            end
            S_HDR: begin
                if (busError || busEndIn) abort_s    = 1'b1;
                else if (dir_rd_r)        state_nx_s = S_RD;
                else                      state_nx_s = S_PRE;
            end
            S_RD: begin
                if (busError || (busEndIn && !(busDataValid && last_beat_s))) abort_s    = 1'b1;
                else if (busDataValid && last_beat_s)                         state_nx_s = S_NEXT;
                else                                                          state_nx_s = S_RD;
            end
            S_PRE: state_nx_s = S_WR;
            S_WR: begin
                if (busError || (busEndIn && !(!busBusy && last_beat_s))) abort_s    = 1'b1;
                else if (!busBusy && last_beat_s)                         state_nx_s = S_NEXT;
                else                                                      state_nx_s = S_WR;
            end
            S_NEXT: begin
                if (remaining_r == {1'b0, hdr_len_r}) state_nx_s = S_IDLE;
                else                                  state_nx_s = S_REQ;
            end
            default: state_nx_s = S_IDLE;
        endcase
        if (abort_s) begin
            state_nx_s = S_IDLE;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // Bus and port B outputs decoded from state; all zero outside the active states
    always_comb begin
        busRequest          = 1'b0;
        busBeginTransaction = 1'b0;
        busAddress          = 32'd0;
        busBurstSize        = 8'd0;
        busReadNotWrite     = 1'b0;
        busDataOut          = 32'd0;
        busDataValidOut     = 1'b0;
        busEndTransaction   = 1'b0;
        ramAddressB         = 9'd0;
        ramWriteEnableB     = 1'b0;
        ramDataOutB         = 32'd0;
        case (state_r)
            S_REQ: busRequest = 1'b1;
            S_HDR: begin
                busRequest          = 1'b1;
                busBeginTransaction = 1'b1;
                busAddress          = wk_bus_r;
                busBurstSize        = hdr_m1_s[7:0];
                busReadNotWrite     = dir_rd_r;
            end
            S_RD: begin
                busRequest      = 1'b1;
                ramAddressB     = wk_mem_r;
                ramDataOutB     = busDataIn;
                ramWriteEnableB = busDataValid && !busError;
            end
            S_PRE: begin
                busRequest  = 1'b1;
                ramAddressB = wk_mem_r;
            end
            S_WR: begin
                busRequest      = 1'b1;
                ramAddressB     = wk_mem_r;
                busDataOut      = fresh_r ? ramDataInB : hold_r;
                busDataValidOut = 1'b1;
            end
            S_NEXT:  busEndTransaction = !dir_rd_r;
            default: ;
        endcase
    end

    // Transfer datapath: working counters, status flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wk_bus_r    <= 32'd0;
            wk_mem_r    <= 9'd0;
            remaining_r <= 10'd0;
            wk_burst_r  <= 8'd0;
            dir_rd_r    <= 1'b0;
            hdr_len_r   <= 9'd0;
            beat_cnt_r  <= 9'd0;
            busy_r      <= 1'b0;
            error_r     <= 1'b0;
        end else if (start_s) begin
            wk_bus_r    <= bus_start_r;
            wk_mem_r    <= mem_start_r;
            remaining_r <= block_r;
            wk_burst_r  <= burst_val_s;
            dir_rd_r    <= (valueB[1:0] == 2'd1);
            busy_r      <= 1'b1;
            error_r     <= 1'b0;
        end else if (abort_s) begin
            busy_r  <= 1'b0;
            error_r <= 1'b1;
        end else begin
            case (state_r)
                S_HDR: begin
                    hdr_len_r  <= hdr_len_s;
                    beat_cnt_r <= 9'd0;
                end
                S_RD: begin
                    if (busDataValid) begin
                        wk_mem_r   <= wk_mem_r + 9'd1;
                        beat_cnt_r <= beat_cnt_r + 9'd1;
                    end
                end
                S_PRE: wk_mem_r <= wk_mem_r + 9'd1;
                S_WR: begin
                    // The address already points one word ahead, so the last beat must not advance it
                    if (!busBusy) begin
                        beat_cnt_r <= beat_cnt_r + 9'd1;
                        if (!last_beat_s) wk_mem_r <= wk_mem_r + 9'd1;
                    end
                end
                S_NEXT: begin
                    wk_bus_r    <= wk_bus_r + {21'd0, hdr_len_r, 2'b00};
                    remaining_r <= remaining_r - {1'b0, hdr_len_r};
                    if (remaining_r == {1'b0, hdr_len_r}) busy_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Write-beat data source: fresh RAM word after a consumed beat, held copy while busBusy stalls
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fresh_r <= 1'b0;
            hold_r  <= 32'd0;
        end else begin
            fresh_r <= (state_r == S_PRE) || ((state_r == S_WR) && !busBusy);
            if (state_r == S_WR) hold_r <= busDataOut;
        end
    end

endmodule

// File: tb/tb_dma_burst_controller.sv
// Directed self-checking bench for dma_burst_controller: CI register access, both transfer directions,
// address wrap, error abort, ignored starts and asynchronous reset. Works with or without DMA_BURST_EN.
`timescale 1ns/1ps
module tb_dma_burst_controller;

`ifdef DMA_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [7:0]  ciN;
    logic        done;
    logic [31:0] result;
    logic [8:0]  ramAddressB;
    logic        ramWriteEnableB;
    logic [31:0] ramDataOutB;
    logic [31:0] ramDataInB;
    logic        busRequest;
    logic        busGrant;
    logic        busBeginTransaction;
    logic [31:0] busAddress;
    logic [7:0]  busBurstSize;
    logic        busReadNotWrite;
    logic [31:0] busDataIn;
    logic        busDataValid;
    logic [31:0] busDataOut;
    logic        busDataValidOut;
    logic        busBusy;
    logic        busEndTransaction;
    logic        busEndIn;
    logic        busError;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:511];

    int          hdr_cnt = 0;
    logic [31:0] hdr_addr [16];
    logic [7:0]  hdr_size [16];
    logic        hdr_rnw  [16];
    int          rd_left = 0;
    int          rd_idx = 0;
    int          err_beat = -1;
    logic [31:0] rd_base = 32'd0;
    int          wcap = 0;
    logic [31:0] wr_cap [16];
    int          busy_left = 0;
    int          held_cycles = 0;
    logic [31:0] held [4];
    int          end_cnt = 0;
    logic        err_seen = 1'b0;
    logic        req_after_err = 1'b1;

    dma_burst_controller #(.customId(8'h00)) dut (
        .clock(clock), .reset(reset), .start(start), .valueA(valueA), .valueB(valueB), .ciN(ciN),
        .done(done), .result(result),
        .ramAddressB(ramAddressB), .ramWriteEnableB(ramWriteEnableB), .ramDataOutB(ramDataOutB),
        .ramDataInB(ramDataInB),
        .busRequest(busRequest), .busGrant(busGrant), .busBeginTransaction(busBeginTransaction),
        .busAddress(busAddress), .busBurstSize(busBurstSize), .busReadNotWrite(busReadNotWrite),
        .busDataIn(busDataIn), .busDataValid(busDataValid),
        .busDataOut(busDataOut), .busDataValidOut(busDataValidOut), .busBusy(busBusy),
        .busEndTransaction(busEndTransaction), .busEndIn(busEndIn), .busError(busError)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scratchpad model with one-cycle read latency
    always @(posedge clock) begin
        if (ramWriteEnableB) ram[ramAddressB] <= ramDataOutB;
        ramDataInB <= ram[ramAddressB];
    end

    // Bus slave: grants, logs headers, supplies read beats, injects errors and write stalls
    initial begin
        busGrant = 1'b0; busDataValid = 1'b0; busDataIn = 32'd0;
        busBusy = 1'b0; busEndIn = 1'b0; busError = 1'b0;
        forever begin
            @(posedge clock); #1;
            busGrant = busRequest;
            busDataValid = 1'b0;
            busError = 1'b0;
            busBusy = 1'b0;
            if (busBeginTransaction) begin
                if (hdr_cnt < 16) begin
                    hdr_addr[hdr_cnt] = busAddress;
                    hdr_size[hdr_cnt] = busBurstSize;
                    hdr_rnw[hdr_cnt]  = busReadNotWrite;
                end
                hdr_cnt++;
                rd_left = busReadNotWrite ? int'(busBurstSize) + 1 : 0;
            end else if (rd_left > 0) begin
                if (rd_idx == err_beat) begin
                    busError = 1'b1;
                    rd_left = 0;
                    err_beat = -1;
                end else begin
                    busDataValid = 1'b1;
                    busDataIn = rd_base + 32'(rd_idx);
                    rd_idx++;
                    rd_left--;
                end
            end
            if (busDataValidOut && wcap == 1 && busy_left > 0) begin
                busBusy = 1'b1;
                busy_left--;
            end
        end
    end

    // Mid-cycle observer of write beats, stalls, end pulses and request after an error
    always @(negedge clock) begin
        if (busDataValidOut) begin
            if (busBusy) begin
                if (held_cycles < 4) held[held_cycles] = busDataOut;
                held_cycles++;
            end else begin
                if (wcap < 16) wr_cap[wcap] = busDataOut;
                wcap++;
            end
        end
        if (busEndTransaction) end_cnt++;
        if (err_seen) begin
            req_after_err = busRequest;
            err_seen = 1'b0;
        end
        if (busError) err_seen = 1'b1;
    end

    task automatic ci(input logic [2:0] sel, input logic wr, input logic [31:0] data,
                      input logic [18:0] upper, input logic chk, output logic [31:0] res);
        start = 1'b1; ciN = 8'h00; valueA = {upper, sel, wr, 9'd0}; valueB = data;
        @(posedge clock); #1;
        start = 1'b0; valueA = 32'd0; valueB = 32'd0;
        if (chk) check("ci_done", {31'd0, done}, 32'd1);
        res = result;
        @(posedge clock); #1;
        if (chk) begin
            check("ci_done_drop", {31'd0, done}, 32'd0);
            check("ci_result_drop", result, 32'd0);
        end
    endtask

    task automatic wr_reg(input logic [2:0] sel, input logic [31:0] data);
        logic [31:0] r;
        ci(sel, 1'b1, data, 19'd0, 1'b1, r);
    endtask

    task automatic rd_reg(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        logic [31:0] r;
        ci(sel, 1'b0, 32'd0, 19'd0, 1'b1, r);
        check(tag, r, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] r;
        int n;
        r = 32'd1;
        n = 0;
        while (r[0] && n < 100) begin
            ci(3'd5, 1'b0, 32'd0, 19'd0, 1'b0, r);
            n++;
        end
        check({tag, "_idle"}, {31'd0, r[0]}, 32'd0);
    endtask

    task automatic check_hdrs(input string tag, input logic [31:0] base, input int words, input logic rnw);
        int beats;
        int nb;
        int len;
        beats = BURST_EN ? 4 : 1;
        nb = (words + beats - 1) / beats;
        check({tag, "_hdr_cnt"}, hdr_cnt, nb);
        for (int i = 0; i < nb && i < 16; i++) begin
            len = (words - i * beats < beats) ? words - i * beats : beats;
            check({tag, "_hdr_addr"}, hdr_addr[i], base + 32'(i * beats * 4));
            check({tag, "_hdr_size"}, {24'd0, hdr_size[i]}, 32'(len - 1));
            check({tag, "_hdr_dir"}, {31'd0, hdr_rnw[i]}, {31'd0, rnw});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        reset = 1'b0; start = 1'b0; valueA = 32'd0; valueB = 32'd0; ciN = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_req", {31'd0, busRequest}, 32'd0);
        check("rst_ram_we", {31'd0, ramWriteEnableB}, 32'd0);
        check("rst_ram_addr", {23'd0, ramAddressB}, 32'd0);
        check("rst_begin", {31'd0, busBeginTransaction}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Register write / read back and decode corner cases
        wr_reg(3'd1, 32'h4000_0003);
        wr_reg(3'd2, 32'd10);
        wr_reg(3'd3, 32'd8);
        wr_reg(3'd4, 32'd3);
        rd_reg("reg1", 3'd1, 32'h4000_0000);
        rd_reg("reg2", 3'd2, 32'd10);
        rd_reg("reg3", 3'd3, 32'd8);
        rd_reg("reg4", 3'd4, BURST_EN ? 32'd3 : 32'd0);
        rd_reg("status_idle", 3'd5, 32'd0);
        ci(3'd2, 1'b1, 32'd99, 19'd1, 1'b1, r);
        check("upper_bits_result", r, 32'd0);
        rd_reg("upper_bits_noeffect", 3'd2, 32'd10);
        ci(3'd6, 1'b0, 32'd0, 19'd0, 1'b1, r);
        check("unknown_sel", r, 32'd0);
        start = 1'b1; ciN = 8'h05; valueA = {19'd0, 3'd1, 1'b0, 9'd0};
        @(posedge clock); #1;
        start = 1'b0; ciN = 8'h00; valueA = 32'd0;
        check("other_id_done", {31'd0, done}, 32'd0);

        // Bus to memory, with an ignored start and a shadow write while busy
        hdr_cnt = 0; rd_idx = 0; rd_base = 32'hA000_0000; err_beat = -1;
        wr_reg(3'd5, 32'd1);
        wr_reg(3'd5, 32'd2);
        wr_reg(3'd2, 32'd300);
        rd_reg("status_busy", 3'd5, 32'd1);
        wait_idle("b2m");
        rd_reg("status_b2m_end", 3'd5, 32'd0);
        rd_reg("reg2_shadow", 3'd2, 32'd300);
        check_hdrs("b2m", 32'h4000_0000, 8, 1'b1);
        for (int i = 0; i < 8; i++) check("b2m_ram", ram[10 + i], 32'hA000_0000 + 32'(i));

        // Block size 0: start ignored
        wr_reg(3'd3, 32'd0);
        hdr_cnt = 0;
        wr_reg(3'd5, 32'd1);
        rd_reg("status_blk0", 3'd5, 32'd0);
        repeat (5) @(posedge clock);
        #1;
        check("blk0_no_hdr", hdr_cnt, 32'd0);

        // Memory to bus with a three-cycle stall on the second beat
        wr_reg(3'd1, 32'h8000_0000);
        wr_reg(3'd2, 32'd10);
        wr_reg(3'd3, 32'd5);
        hdr_cnt = 0; wcap = 0; busy_left = 3; held_cycles = 0; end_cnt = 0;
        wr_reg(3'd5, 32'd2);
        wait_idle("m2b");
        rd_reg("status_m2b_end", 3'd5, 32'd0);
        check_hdrs("m2b", 32'h8000_0000, 5, 1'b0);
        check("m2b_beats", wcap, 32'd5);
        for (int i = 0; i < 5; i++) check("m2b_data", wr_cap[i], 32'hA000_0000 + 32'(i));
        check("m2b_held_cycles", held_cycles, 32'd3);
        for (int i = 0; i < 3; i++) check("m2b_held_data", held[i], 32'hA000_0001);
        check("m2b_end_pulses", end_cnt, BURST_EN ? 32'd2 : 32'd5);

        // Memory address wrap 510 -> 1
        wr_reg(3'd1, 32'h1000_0000);
        wr_reg(3'd2, 32'd510);
        wr_reg(3'd3, 32'd4);
        hdr_cnt = 0; rd_idx = 0; rd_base = 32'hB000_0000;
        wr_reg(3'd5, 32'd1);
        wait_idle("wrap");
        check("wrap_510", ram[510], 32'hB000_0000);
        check("wrap_511", ram[511], 32'hB000_0001);
        check("wrap_0", ram[0], 32'hB000_0002);
        check("wrap_1", ram[1], 32'hB000_0003);
        check_hdrs("wrap", 32'h1000_0000, 4, 1'b1);

        // Bus error on the third read beat, then a clean restart
        wr_reg(3'd2, 32'd20);
        wr_reg(3'd3, 32'd8);
        hdr_cnt = 0; rd_idx = 0; rd_base = 32'hC000_0000; err_beat = 2; req_after_err = 1'b1;
        wr_reg(3'd5, 32'd1);
        wait_idle("err");
        rd_reg("status_error", 3'd5, 32'd2);
        check("req_drop_after_err", {31'd0, req_after_err}, 32'd0);
        rd_reg("reg3_after_err", 3'd3, 32'd8);
        rd_idx = 0; rd_base = 32'hD000_0000; err_beat = -1;
        wr_reg(3'd5, 32'd1);
        rd_reg("status_restart", 3'd5, 32'd1);
        wait_idle("restart");
        rd_reg("status_restart_end", 3'd5, 32'd0);
        for (int i = 0; i < 8; i++) check("restart_ram", ram[20 + i], 32'hD000_0000 + 32'(i));

        // Asynchronous reset in the middle of a transfer
        wr_reg(3'd5, 32'd1);
        check("req_before_reset", {31'd0, busRequest}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_req", {31'd0, busRequest}, 32'd0);
        check("async_reset_begin", {31'd0, busBeginTransaction}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        rd_reg("status_after_reset", 3'd5, 32'd0);
        rd_reg("reg1_after_reset", 3'd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
